// File: rtl/mem_wb_stage.sv
// MEM/WB stage of the 10-bit CPU: data-memory access over req/ready and GP register writeback.
// Stalls upstream while a memory access is outstanding; aborts stuck accesses after TIMEOUT cycles.
module mem_wb_stage #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic              ex_gp_reg_wb,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                gp_q, gp_d;
    logic                req_d, we_d, wb_en_d, err_d;
    logic [DATA_W-1:0]   addr_d, wdata_d, wb_data_d;
    logic [ADDR_W-1:0]   wb_addr_d;

    assign stall = (state_q == MEM_WAIT);

    // Next-state and next-output logic; everything holds unless an event below updates it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        gp_d      = gp_q;
        req_d     = mem_req;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr;
        wb_data_d = wb_data;
        err_d     = err;

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_mem_read && ex_mem_write) begin
                        err_d = 1'b1;
                    end else if (ex_mem_read || ex_mem_write) begin
                        addr_d  = ex_alu_result;
                        wdata_d = ex_store_data;
                        we_d    = ex_mem_write;
                        rd_d    = ex_rd_addr;
                        gp_d    = ex_gp_reg_wb;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = MEM_WAIT;
                    end else begin
                        wb_en_d   = ex_gp_reg_wb;
                        wb_addr_d = ex_rd_addr;
                        wb_data_d = ex_alu_result;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!mem_we) begin
                        wb_en_d   = gp_q;
                        wb_addr_d = rd_q;
                        wb_data_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Ready on the final cycle still wins; only a silent memory aborts.
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            gp_q      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            gp_q      <= gp_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            wb_en     <= wb_en_d;
            wb_addr   <= wb_addr_d;
            wb_data   <= wb_data_d;
            err       <= err_d;
        end
    end

endmodule
